// File: rtl/viterbi_wifi_pkg.sv
// -----------------------------------------------------------------------------
// viterbi_wifi_pkg
// Shared definitions for the WiFi Viterbi input buffer: code-rate encodings,
// frame state enum, and the 802.11 depuncturing patterns (period, entries
// consumed per pair, and {eraseA, eraseB} flags for each phase).
// -----------------------------------------------------------------------------
package viterbi_wifi_pkg;

    typedef enum logic [1:0] {
        RATE_1_2  = 2'b00,
        RATE_2_3  = 2'b01,
        RATE_3_4  = 2'b10,
        RATE_RSVD = 2'b11
    } rate_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Pattern period (number of phases) per rate.
    localparam logic [1:0] PERIOD_1_2 = 2'd1;
    localparam logic [1:0] PERIOD_2_3 = 2'd2;
    localparam logic [1:0] PERIOD_3_4 = 2'd3;

    // Per-phase tables, element [p] belongs to phase p. Unused phases are
    // filled with the phase-0 values so an index can never produce garbage.
    localparam logic [2:0][1:0] NEED_1_2  = {2'd2, 2'd2, 2'd2};
    localparam logic [2:0][1:0] NEED_2_3  = {2'd2, 2'd1, 2'd2};
    localparam logic [2:0][1:0] NEED_3_4  = {2'd1, 2'd1, 2'd2};

    localparam logic [2:0][1:0] ERASE_1_2 = {2'b00, 2'b00, 2'b00};
    localparam logic [2:0][1:0] ERASE_2_3 = {2'b00, 2'b01, 2'b00};
    localparam logic [2:0][1:0] ERASE_3_4 = {2'b10, 2'b01, 2'b00};

    // The reserved encoding behaves exactly like rate 1/2.
    function automatic rate_e norm_rate(input logic [1:0] r);
        return (r == 2'b11) ? RATE_1_2 : rate_e'(r);
    endfunction

    function automatic logic [1:0] pat_period(input rate_e r);
        case (r)
            RATE_2_3: return PERIOD_2_3;
            RATE_3_4: return PERIOD_3_4;
            default:  return PERIOD_1_2;
        endcase
    endfunction

    function automatic logic [1:0] pat_need(input rate_e r, input logic [1:0] ph);
        case (r)
            RATE_2_3: return NEED_2_3[ph];
            RATE_3_4: return NEED_3_4[ph];
            default:  return NEED_1_2[ph];
        endcase
    endfunction

    function automatic logic [1:0] pat_erase(input rate_e r, input logic [1:0] ph);
        case (r)
            RATE_2_3: return ERASE_2_3[ph];
            RATE_3_4: return ERASE_3_4[ph];
            default:  return ERASE_1_2[ph];
        endcase
    endfunction

endpackage

// File: rtl/dpn_fifo_mem.sv
// -----------------------------------------------------------------------------
// dpn_fifo_mem
// DEPTH x SOFT_W storage for the depuncturing buffer. One synchronous write
// port, two asynchronous read ports (A and B of a pair are read together).
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr0_i : read address, port 0
//   raddr1_i : read address, port 1
//   rdata0_o : read data, port 0
//   rdata1_o : read data, port 1
// -----------------------------------------------------------------------------
module dpn_fifo_mem #(
    parameter int DEPTH  = 8192,
    parameter int SOFT_W = 1,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [SOFT_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr0_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [SOFT_W-1:0] rdata0_o,
    output logic [SOFT_W-1:0] rdata1_o
);

    // Data storage carries no reset; contents are meaningless outside a frame.
    logic [SOFT_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/viterbi_depuncture_fifo.sv
// -----------------------------------------------------------------------------
// viterbi_depuncture_fifo
// Input buffer for the WiFi Viterbi decoder. Collects serial coded samples,
// re-inserts punctured positions (rate 1/2, 2/3, 3/4) and hands out {A,B}
// pairs with erasure flags on request.
//   clk        : rising-edge clock
//   RESET      : asynchronous active-low reset
//   enable     : frame window, high = write phase open
//   rate       : 00=1/2, 01=2/3, 10=3/4, 11=1/2; latched at frame start
//   valid_in   : data_in strobe
//   data_in    : coded sample
//   re         : consumer pair request (level, retried every cycle)
//   code_out   : {A,B}; an erased half reads 0
//   erase_out  : {eraseA, eraseB}
//   valid_out  : one-cycle strobe per delivered pair
//   level      : stored entries
//   full/empty : level == DEPTH / level == 0
//   overflow   : sticky dropped-write flag, cleared at frame start
//   frame_done : one-cycle pulse at frame end
// -----------------------------------------------------------------------------
module viterbi_depuncture_fifo
    import viterbi_wifi_pkg::*;
#(
    parameter  int DEPTH  = 8192,
    parameter  int SOFT_W = 1,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                RESET,
    input  logic                enable,
    input  logic [1:0]          rate,
    input  logic                valid_in,
    input  logic [SOFT_W-1:0]   data_in,
    input  logic                re,
    output logic [2*SOFT_W-1:0] code_out,
    output logic [1:0]          erase_out,
    output logic                valid_out,
    output logic [ADDR_W:0]     level,
    output logic                full,
    output logic                empty,
    output logic                overflow,
    output logic                frame_done
);

    state_e              state_q,  state_d;
    rate_e               rate_q,   rate_d;
    logic [1:0]          phase_q,  phase_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     level_q,  level_d;
    logic                ovf_q,    ovf_d;
    logic [2*SOFT_W-1:0] code_q,   code_d;
    logic [1:0]          erase_q,  erase_d;
    logic                valid_q,  valid_d;

    logic [1:0]          need_cur;
    logic [1:0]          erase_cur;
    logic [1:0]          period_cur;
    logic [ADDR_W:0]     need_ext;
    logic                full_w;
    logic                serving;
    logic                rd_acc;
    logic                wr_req;
    logic                wr_acc;
    logic [ADDR_W-1:0]   rd_ptr1;
    logic [SOFT_W-1:0]   rd_data0;
    logic [SOFT_W-1:0]   rd_data1;

    localparam logic [SOFT_W-1:0] ZERO_S = '0;

    assign need_cur   = pat_need(rate_q, phase_q);
    assign erase_cur  = pat_erase(rate_q, phase_q);
    assign period_cur = pat_period(rate_q);
    assign need_ext   = (ADDR_W+1)'(need_cur);

    assign full_w  = (level_q == (ADDR_W+1)'(DEPTH));
    assign serving = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign rd_acc  = re && serving && (level_q >= need_ext);
    assign wr_req  = valid_in && (state_q == ST_RUN);
    // A read in the same cycle frees at least one slot, so a full buffer
    // can still take the write.
    assign wr_acc  = wr_req && (!full_w || rd_acc);
    assign rd_ptr1 = rd_ptr_q + ADDR_W'(1);

    dpn_fifo_mem #(
        .DEPTH  (DEPTH),
        .SOFT_W (SOFT_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk      (clk),
        .we_i     (wr_acc),
        .waddr_i  (wr_ptr_q),
        .wdata_i  (data_in),
        .raddr0_i (rd_ptr_q),
        .raddr1_i (rd_ptr1),
        .rdata0_o (rd_data0),
        .rdata1_o (rd_data1)
    );

    always_comb begin
        state_d  = state_q;
        rate_d   = rate_q;
        phase_d  = phase_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q + (ADDR_W+1)'(wr_acc) - (rd_acc ? need_ext : '0);
        ovf_d    = ovf_q || (wr_req && full_w && !rd_acc);
        code_d   = code_q;
        erase_d  = erase_q;
        valid_d  = rd_acc;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end

        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(need_cur);
            phase_d  = (phase_q == period_cur - 2'd1) ? 2'd0 : phase_q + 2'd1;
            erase_d  = erase_cur;
            // A single stored bit lands in whichever half is not erased.
            case (erase_cur)
                2'b01:   code_d = {rd_data0, ZERO_S};
                2'b10:   code_d = {ZERO_S, rd_data0};
                default: code_d = {rd_data0, rd_data1};
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d  = ST_RUN;
                    rate_d   = norm_rate(rate);
                    phase_d  = 2'd0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    level_d  = '0;
                    ovf_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((level_q < need_ext) && !rd_acc) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                // Residue that cannot form a full pair is thrown away here.
                state_d  = ST_IDLE;
                phase_d  = 2'd0;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                level_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            rate_q   <= RATE_1_2;
            phase_q  <= 2'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            code_q   <= '0;
            erase_q  <= 2'b00;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rate_q   <= rate_d;
            phase_q  <= phase_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            code_q   <= code_d;
            erase_q  <= erase_d;
            valid_q  <= valid_d;
        end
    end

    assign code_out   = code_q;
    assign erase_out  = erase_q;
    assign valid_out  = valid_q;
    assign level      = level_q;
    assign full       = full_w;
    assign empty      = (level_q == '0);
    assign overflow   = ovf_q;
    assign frame_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_viterbi_depuncture_fifo.sv
// -----------------------------------------------------------------------------
// tb_viterbi_depuncture_fifo
// Directed bench: a default-depth instance and a DEPTH=4 instance share the
// same stimulus; each scenario checks the instance it targets.
// -----------------------------------------------------------------------------
module tb_viterbi_depuncture_fifo;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [1:0]  rate;
    logic        valid_in;
    logic [0:0]  data_in;
    logic        re;

    logic [1:0]  code_b, erase_b;
    logic        valid_b, full_b, empty_b, ovf_b, fd_b;
    logic [13:0] level_b;

    logic [1:0]  code_s, erase_s;
    logic        valid_s, full_s, empty_s, ovf_s, fd_s;
    logic [2:0]  level_s;

    int n_chk = 0;
    int n_err = 0;

    viterbi_depuncture_fifo u_dut (
        .clk        (clk),
        .RESET      (rst_n),
        .enable     (enable),
        .rate       (rate),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .re         (re),
        .code_out   (code_b),
        .erase_out  (erase_b),
        .valid_out  (valid_b),
        .level      (level_b),
        .full       (full_b),
        .empty      (empty_b),
        .overflow   (ovf_b),
        .frame_done (fd_b)
    );

    viterbi_depuncture_fifo #(.DEPTH(4)) u_small (
        .clk        (clk),
        .RESET      (rst_n),
        .enable     (enable),
        .rate       (rate),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .re         (re),
        .code_out   (code_s),
        .erase_out  (erase_s),
        .valid_out  (valid_s),
        .level      (level_s),
        .full       (full_s),
        .empty      (empty_s),
        .overflow   (ovf_s),
        .frame_done (fd_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic d);
        valid_in   = 1'b1;
        data_in[0] = d;
        step();
        valid_in   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        rate     = 2'b00;
        valid_in = 1'b0;
        data_in  = 1'b0;
        re       = 1'b0;
        #2;
        chk("rst_code",  32'(code_b),  32'd0);
        chk("rst_erase", 32'(erase_b), 32'd0);
        chk("rst_valid", 32'(valid_b), 32'd0);
        chk("rst_level", 32'(level_b), 32'd0);
        chk("rst_full",  32'(full_b),  32'd0);
        chk("rst_empty", 32'(empty_b), 32'd1);
        chk("rst_ovf",   32'(ovf_b),   32'd0);
        chk("rst_fd",    32'(fd_b),    32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Rate 1/2: 1,0,1,1 -> {1,0} then {1,1}
        rate = 2'b00; enable = 1'b1;
        step();
        wr(1'b1); wr(1'b0); wr(1'b1); wr(1'b1);
        chk("r12_level4", 32'(level_b), 32'd4);
        chk("r12_nempty", 32'(empty_b), 32'd0);
        re = 1'b1;
        step();
        chk("r12_v1",     32'(valid_b), 32'd1);
        chk("r12_code1",  32'(code_b),  32'b10);
        chk("r12_erase1", 32'(erase_b), 32'b00);
        chk("r12_lvl2",   32'(level_b), 32'd2);
        step();
        chk("r12_v2",     32'(valid_b), 32'd1);
        chk("r12_code2",  32'(code_b),  32'b11);
        chk("r12_lvl0",   32'(level_b), 32'd0);
        chk("r12_empty",  32'(empty_b), 32'd1);
        re = 1'b0; enable = 1'b0;
        step();
        chk("r12_vdrop",  32'(valid_b), 32'd0);
        chk("r12_nofd",   32'(fd_b),    32'd0);
        step();
        chk("r12_fd",     32'(fd_b),    32'd1);
        step();
        chk("r12_fdend",  32'(fd_b),    32'd0);

        // Rate 3/4, rate input changed after start must be ignored
        rate = 2'b10; enable = 1'b1;
        step();
        rate = 2'b00;
        wr(1'b1); wr(1'b1); wr(1'b0); wr(1'b1);
        chk("r34_level4", 32'(level_b), 32'd4);
        re = 1'b1;
        step();
        chk("r34_code0",  32'(code_b),  32'b11);
        chk("r34_er0",    32'(erase_b), 32'b00);
        chk("r34_lvl2",   32'(level_b), 32'd2);
        step();
        chk("r34_code1",  32'(code_b),  32'b00);
        chk("r34_er1",    32'(erase_b), 32'b01);
        chk("r34_lvl1",   32'(level_b), 32'd1);
        step();
        chk("r34_code2",  32'(code_b),  32'b01);
        chk("r34_er2",    32'(erase_b), 32'b10);
        chk("r34_lvl0",   32'(level_b), 32'd0);
        chk("r34_v2",     32'(valid_b), 32'd1);
        re = 1'b0; enable = 1'b0;
        step();
        step();
        chk("r34_fd",     32'(fd_b),    32'd1);
        step();

        // Rate 2/3: phase 0 starved with one entry, then completes
        rate = 2'b01; enable = 1'b1;
        step();
        wr(1'b1);
        re = 1'b1;
        step();
        chk("r23_starve", 32'(valid_b), 32'd0);
        chk("r23_lvl1",   32'(level_b), 32'd1);
        valid_in = 1'b1; data_in = 1'b0;
        step();
        valid_in = 1'b0;
        chk("r23_wrcyc",  32'(valid_b), 32'd0);
        chk("r23_lvl2",   32'(level_b), 32'd2);
        step();
        chk("r23_v0",     32'(valid_b), 32'd1);
        chk("r23_code0",  32'(code_b),  32'b10);
        chk("r23_er0",    32'(erase_b), 32'b00);
        chk("r23_lvl0",   32'(level_b), 32'd0);
        re = 1'b0;
        wr(1'b1);
        chk("r23_idle_v", 32'(valid_b), 32'd0);
        re = 1'b1;
        step();
        chk("r23_v1",     32'(valid_b), 32'd1);
        chk("r23_code1",  32'(code_b),  32'b10);
        chk("r23_er1",    32'(erase_b), 32'b01);
        chk("r23_lvl_e",  32'(level_b), 32'd0);
        re = 1'b0; enable = 1'b0;
        step();
        step();
        chk("r23_fd",     32'(fd_b),    32'd1);
        step();

        // DEPTH=4 overflow, then write+read while full
        rate = 2'b00; enable = 1'b1;
        step();
        wr(1'b1); wr(1'b0); wr(1'b1); wr(1'b1);
        chk("d4_full",    32'(full_s),  32'd1);
        chk("d4_lvl4",    32'(level_s), 32'd4);
        chk("d4_noovf",   32'(ovf_s),   32'd0);
        wr(1'b0); wr(1'b0);
        chk("d4_lvlhold", 32'(level_s), 32'd4);
        chk("d4_ovf",     32'(ovf_s),   32'd1);
        chk("d4_fullh",   32'(full_s),  32'd1);
        chk("big_lvl6",   32'(level_b), 32'd6);
        valid_in = 1'b1; data_in = 1'b1; re = 1'b1;
        step();
        valid_in = 1'b0; re = 1'b0;
        chk("d4_rwlvl",   32'(level_s), 32'd3);
        chk("d4_rwv",     32'(valid_s), 32'd1);
        chk("d4_rwcode",  32'(code_s),  32'b10);
        chk("d4_rwer",    32'(erase_s), 32'b00);
        chk("d4_nfull",   32'(full_s),  32'd0);
        chk("big_lvl5",   32'(level_b), 32'd5);

        // Asynchronous reset in the middle of RUN
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_lvl",     32'(level_b), 32'd0);
        chk("ar_empty",   32'(empty_b), 32'd1);
        chk("ar_valid",   32'(valid_b), 32'd0);
        chk("ar_code",    32'(code_b),  32'd0);
        chk("ar_lvls",    32'(level_s), 32'd0);
        chk("ar_ovfs",    32'(ovf_s),   32'd0);
        chk("ar_fulls",   32'(full_s),  32'd0);
        chk("ar_emptys",  32'(empty_s), 32'd1);
        chk("ar_fds",     32'(fd_s),    32'd0);
        step();
        rst_n = 1'b1;
        chk("ar_hold",    32'(level_b), 32'd0);

        // New frame, rate 1/2 with odd residue
        step();
        wr(1'b1); wr(1'b1); wr(1'b0);
        chk("res_lvl3",   32'(level_b), 32'd3);
        chk("res_ovf",    32'(ovf_s),   32'd0);
        enable = 1'b0; re = 1'b1;
        step();
        chk("res_v",      32'(valid_b), 32'd1);
        chk("res_code",   32'(code_b),  32'b11);
        chk("res_lvl1",   32'(level_b), 32'd1);
        step();
        chk("res_nov",    32'(valid_b), 32'd0);
        chk("res_fd",     32'(fd_b),    32'd1);
        step();
        chk("res_fdend",  32'(fd_b),    32'd0);
        chk("res_lvl0",   32'(level_b), 32'd0);
        chk("res_empty",  32'(empty_b), 32'd1);
        re = 1'b0;
        step();
        chk("res_idle_v", 32'(valid_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
